// File: rtl/fib_seq_ctrl.sv
// Successor controller for the bus-based Fibonacci datapath: loads n, runs the recurrence, reports done/overflow.
// Optional single-step PAUSE state is enabled by defining FIB_SEQ_CTRL_SSTEP_EN (adds the sstep input).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a press, all outputs low
// LD_N      | switches -> N
// INIT_M    | N-1 -> M
// INIT_P    | 1 -> P
// INIT_PP   | 1 -> PP
// TEST      | M-1 on the ALU (no load), borrow or iteration cap ends the loop
// ADD       | P+PP -> OUT
// SHIFT     | P -> PP
// WB        | OUT -> P
// DEC       | M-1 -> M, count one finished iteration
// FIN       | P -> OUT
// DONE      | result ready, over/ovf held until the next press
// PAUSE     | single-step hold after DEC (optional build only)
module fib_seq_ctrl #(
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 255,
  parameter int F_W      = 3,
  parameter int F_PASSA  = 2,
  parameter int F_PASSB  = 3,
  parameter int F_DEC    = 4,
  parameter int F_ADD    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             bo,
`ifdef FIB_SEQ_CTRL_SSTEP_EN
  input  logic             sstep,
`endif
  output logic [F_W-1:0]   f,
  output logic             tsw,
  output logic             tn,
  output logic             tm,
  output logic             tp,
  output logic             tpp,
  output logic             tout,
  output logic             tone,
  output logic             ldn,
  output logic             ldm,
  output logic             ldp,
  output logic             ldpp,
  output logic             ldout,
  output logic             over,
  output logic             ovf,
  output logic             busy,
  output logic [CNT_W-1:0] iter
);

  localparam logic [F_W-1:0]   FC_PASSA = F_W'(F_PASSA);
  localparam logic [F_W-1:0]   FC_PASSB = F_W'(F_PASSB);
  localparam logic [F_W-1:0]   FC_DEC   = F_W'(F_DEC);
  localparam logic [F_W-1:0]   FC_ADD   = F_W'(F_ADD);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_ITER);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_N,
    S_INIT_M,
    S_INIT_P,
    S_INIT_PP,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_WB,
    S_DEC,
    S_FIN,
    S_DONE
`ifdef FIB_SEQ_CTRL_SSTEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t state, state_nxt;

  logic             go_s1, go_s2, go_s3;
  logic             press;
  logic             abortable;
  logic [CNT_W-1:0] iter_nxt;
  logic             ovf_hit, ovf_hit_nxt;

  logic [F_W-1:0]   f_d;
  logic             tsw_d, tn_d, tm_d, tp_d, tpp_d, tout_d, tone_d;
  logic             ldn_d, ldm_d, ldp_d, ldpp_d, ldout_d;
  logic             over_d, ovf_d, busy_d;

  // go_s3 only serves the edge detector, so a level held high yields one press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_s1 <= 1'b0;
      go_s2 <= 1'b0;
      go_s3 <= 1'b0;
    end else begin
      go_s1 <= go;
      go_s2 <= go_s1;
      go_s3 <= go_s2;
    end
  end

  assign press = go_s2 & ~go_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      iter    <= '0;
      ovf_hit <= 1'b0;
    end else begin
      state   <= state_nxt;
      iter    <= iter_nxt;
      ovf_hit <= ovf_hit_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    iter_nxt    = iter;
    ovf_hit_nxt = ovf_hit;
    abortable   = 1'b1;
    case (state)
      S_IDLE: begin
        abortable = 1'b0;
        if (press) state_nxt = S_LD_N;
      end
      S_LD_N:    state_nxt = S_INIT_M;
      S_INIT_M:  state_nxt = S_INIT_P;
      S_INIT_P:  state_nxt = S_INIT_PP;
      S_INIT_PP: state_nxt = S_TEST;
      S_TEST: begin
        if (bo) begin
          state_nxt   = S_FIN;
          ovf_hit_nxt = 1'b0;
        end else if (iter == MAX_C) begin
          state_nxt   = S_FIN;
          ovf_hit_nxt = 1'b1;
        end else begin
          state_nxt = S_ADD;
        end
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = S_WB;
      S_WB:    state_nxt = S_DEC;
      S_DEC: begin
        iter_nxt  = iter + ONE_C;
`ifdef FIB_SEQ_CTRL_SSTEP_EN
        state_nxt = sstep ? S_PAUSE : S_TEST;
`else
        state_nxt = S_TEST;
`endif
      end
      S_FIN: state_nxt = S_DONE;
      S_DONE: begin
        abortable = 1'b0;
        if (press) state_nxt = S_IDLE;
      end
`ifdef FIB_SEQ_CTRL_SSTEP_EN
      S_PAUSE: begin
        abortable = 1'b0;
        if (press) state_nxt = S_TEST;
      end
`endif
      default: begin
        abortable = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase

    // abort wins over everything decided above, including the borrow exit from TEST
    if (press && abortable) state_nxt = S_IDLE;

    if (state_nxt == S_IDLE || state_nxt == S_LD_N) begin
      iter_nxt    = '0;
      ovf_hit_nxt = 1'b0;
    end
  end

  // Moore outputs decoded from the state being entered, then registered
  always_comb begin
    f_d     = '0;
    tsw_d   = 1'b0;
    tn_d    = 1'b0;
    tm_d    = 1'b0;
    tp_d    = 1'b0;
    tpp_d   = 1'b0;
    tout_d  = 1'b0;
    tone_d  = 1'b0;
    ldn_d   = 1'b0;
    ldm_d   = 1'b0;
    ldp_d   = 1'b0;
    ldpp_d  = 1'b0;
    ldout_d = 1'b0;
    over_d  = 1'b0;
    ovf_d   = 1'b0;
    busy_d  = 1'b1;
    case (state_nxt)
      S_IDLE: busy_d = 1'b0;
      S_LD_N: begin
        tsw_d = 1'b1;
        ldn_d = 1'b1;
        f_d   = FC_PASSA;
      end
      S_INIT_M: begin
        tn_d   = 1'b1;
        tone_d = 1'b1;
        ldm_d  = 1'b1;
        f_d    = FC_DEC;
      end
      S_INIT_P: begin
        tone_d = 1'b1;
        ldp_d  = 1'b1;
        f_d    = FC_PASSB;
      end
      S_INIT_PP: begin
        tone_d = 1'b1;
        ldpp_d = 1'b1;
        f_d    = FC_PASSB;
      end
      S_TEST: begin
        tm_d   = 1'b1;
        tone_d = 1'b1;
        f_d    = FC_DEC;
      end
      S_ADD: begin
        tp_d    = 1'b1;
        tpp_d   = 1'b1;
        ldout_d = 1'b1;
        f_d     = FC_ADD;
      end
      S_SHIFT: begin
        tp_d   = 1'b1;
        ldpp_d = 1'b1;
        f_d    = FC_PASSA;
      end
      S_WB: begin
        tout_d = 1'b1;
        ldp_d  = 1'b1;
        f_d    = FC_PASSB;
      end
      S_DEC: begin
        tm_d   = 1'b1;
        tone_d = 1'b1;
        ldm_d  = 1'b1;
        f_d    = FC_DEC;
      end
      // P is copied out here so a run with zero iterations still reports the seed
      S_FIN: begin
        tp_d    = 1'b1;
        ldout_d = 1'b1;
        f_d     = FC_PASSA;
      end
      S_DONE: begin
        busy_d = 1'b0;
        over_d = 1'b1;
        ovf_d  = ovf_hit_nxt;
      end
`ifdef FIB_SEQ_CTRL_SSTEP_EN
      S_PAUSE: busy_d = 1'b1;
`endif
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f     <= '0;
      tsw   <= 1'b0;
      tn    <= 1'b0;
      tm    <= 1'b0;
      tp    <= 1'b0;
      tpp   <= 1'b0;
      tout  <= 1'b0;
      tone  <= 1'b0;
      ldn   <= 1'b0;
      ldm   <= 1'b0;
      ldp   <= 1'b0;
      ldpp  <= 1'b0;
      ldout <= 1'b0;
      over  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      f     <= f_d;
      tsw   <= tsw_d;
      tn    <= tn_d;
      tm    <= tm_d;
      tp    <= tp_d;
      tpp   <= tpp_d;
      tout  <= tout_d;
      tone  <= tone_d;
      ldn   <= ldn_d;
      ldm   <= ldm_d;
      ldp   <= ldp_d;
      ldpp  <= ldpp_d;
      ldout <= ldout_d;
      over  <= over_d;
      ovf   <= ovf_d;
      busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench for fib_seq_ctrl: two instances (default cap 255, cap 3) checked every cycle against a run-schedule model.
// The single-step section is compiled only when FIB_SEQ_CTRL_SSTEP_EN is defined.
module tb_fib_seq_ctrl;
  localparam int CNT_W = 8;
  localparam int F_W   = 3;
  localparam int PLEN  = 2048;

  typedef enum {K_IDLE, K_LDN, K_INITM, K_INITP, K_INITPP, K_TEST, K_ADD, K_SHIFT,
                K_WB, K_DEC, K_PAUSE, K_FIN, K_DONE} kind_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  logic [1:0] bo = 2'b00;
`ifdef FIB_SEQ_CTRL_SSTEP_EN
  logic sstep = 1'b0;
`endif

  wire [F_W-1:0]   f_o [2];
  wire [CNT_W-1:0] iter_o [2];
  wire [1:0] tsw, tn, tm, tp, tpp, tout, tone, ldn, ldm, ldp, ldpp, ldout, over, ovf, busy;

  int checks   = 0;
  int failures = 0;
  int bo_at    = 0;

  always #5 clk = ~clk;

  fib_seq_ctrl dut0 (
    .clk(clk), .rst(rst), .go(go), .bo(bo[0]),
`ifdef FIB_SEQ_CTRL_SSTEP_EN
    .sstep(sstep),
`endif
    .f(f_o[0]), .tsw(tsw[0]), .tn(tn[0]), .tm(tm[0]), .tp(tp[0]), .tpp(tpp[0]),
    .tout(tout[0]), .tone(tone[0]), .ldn(ldn[0]), .ldm(ldm[0]), .ldp(ldp[0]),
    .ldpp(ldpp[0]), .ldout(ldout[0]), .over(over[0]), .ovf(ovf[0]), .busy(busy[0]),
    .iter(iter_o[0])
  );

  fib_seq_ctrl #(.MAX_ITER(3)) dut1 (
    .clk(clk), .rst(rst), .go(go), .bo(bo[1]),
`ifdef FIB_SEQ_CTRL_SSTEP_EN
    .sstep(sstep),
`endif
    .f(f_o[1]), .tsw(tsw[1]), .tn(tn[1]), .tm(tm[1]), .tp(tp[1]), .tpp(tpp[1]),
    .tout(tout[1]), .tone(tone[1]), .ldn(ldn[1]), .ldm(ldm[1]), .ldp(ldp[1]),
    .ldpp(ldpp[1]), .ldout(ldout[1]), .over(over[1]), .ovf(ovf[1]), .busy(busy[1]),
    .iter(iter_o[1])
  );

  // ---------------- model: a precomputed schedule of steps per run ----------------
  kind_t pk [2][PLEN];
  int    pi [2][PLEN];
  bit    po [2][PLEN];
  int    pos [2] = '{-1, -1};
  bit [2:0] gh = 3'b000;

  function automatic kind_t cur_kind(input int u);
    return (pos[u] < 0) ? K_IDLE : pk[u][pos[u]];
  endfunction

  function automatic int cur_iter(input int u);
    return (pos[u] < 0) ? 0 : pi[u][pos[u]];
  endfunction

  // {f, tsw,tn,tm,tp,tpp,tout,tone, ldn,ldm,ldp,ldpp,ldout, over,ovf,busy, iter}
  function automatic logic [25:0] exp_vec(input kind_t k, input int it, input bit ov);
    logic [2:0] fv;
    logic [6:0] t;
    logic [4:0] ld;
    logic ovr, ovv, bsy;
    fv = 3'd0; t = 7'b0; ld = 5'b0; ovr = 1'b0; ovv = 1'b0; bsy = 1'b1;
    case (k)
      K_IDLE:   bsy = 1'b0;
      K_LDN:    begin fv = 3'd2; t = 7'b1000000; ld = 5'b10000; end
      K_INITM:  begin fv = 3'd4; t = 7'b0100001; ld = 5'b01000; end
      K_INITP:  begin fv = 3'd3; t = 7'b0000001; ld = 5'b00100; end
      K_INITPP: begin fv = 3'd3; t = 7'b0000001; ld = 5'b00010; end
      K_TEST:   begin fv = 3'd4; t = 7'b0010001; end
      K_ADD:    begin fv = 3'd5; t = 7'b0001100; ld = 5'b00001; end
      K_SHIFT:  begin fv = 3'd2; t = 7'b0001000; ld = 5'b00010; end
      K_WB:     begin fv = 3'd3; t = 7'b0000010; ld = 5'b00100; end
      K_DEC:    begin fv = 3'd4; t = 7'b0010001; ld = 5'b01000; end
      K_PAUSE:  bsy = 1'b1;
      K_FIN:    begin fv = 3'd2; t = 7'b0001000; ld = 5'b00001; end
      K_DONE:   begin bsy = 1'b0; ovr = 1'b1; ovv = ov; end
      default:  bsy = 1'b0;
    endcase
    return {fv, t, ld, ovr, ovv, bsy, 8'(it)};
  endfunction

  function automatic logic [25:0] act_vec(input int u);
    return {f_o[u], tsw[u], tn[u], tm[u], tp[u], tpp[u], tout[u], tone[u],
            ldn[u], ldm[u], ldp[u], ldpp[u], ldout[u], over[u], ovf[u], busy[u], iter_o[u]};
  endfunction

  task automatic put(input int u, input int n, input kind_t k, input int it, input bit ov);
    pk[u][n] = k;
    pi[u][n] = it;
    po[u][n] = ov;
  endtask

  // Run length follows from which TEST sees bo=1 versus the iteration cap.
  task automatic build(input int u);
    int mi, kk, n;
    bit ov, ss;
    mi = (u == 0) ? 255 : 3;
    ss = 1'b0;
`ifdef FIB_SEQ_CTRL_SSTEP_EN
    ss = sstep;
`endif
    if (bo_at != 0 && bo_at <= mi + 1) begin kk = bo_at - 1; ov = 1'b0; end
    else begin kk = mi; ov = 1'b1; end
    n = 0;
    put(u, n, K_LDN, 0, 0);    n++;
    put(u, n, K_INITM, 0, 0);  n++;
    put(u, n, K_INITP, 0, 0);  n++;
    put(u, n, K_INITPP, 0, 0); n++;
    for (int i = 0; i < kk; i++) begin
      put(u, n, K_TEST, i, 0);  n++;
      put(u, n, K_ADD, i, 0);   n++;
      put(u, n, K_SHIFT, i, 0); n++;
      put(u, n, K_WB, i, 0);    n++;
      put(u, n, K_DEC, i, 0);   n++;
      if (ss) begin put(u, n, K_PAUSE, i + 1, 0); n++; end
    end
    put(u, n, K_TEST, kk, 0); n++;
    put(u, n, K_FIN, kk, 0);  n++;
    put(u, n, K_DONE, kk, ov);
  endtask

  // a press acts at the edge where go was seen high two edges ago and low three edges ago
  always @(posedge clk or posedge rst) begin : model
    bit press;
    kind_t k;
    if (rst) begin
      pos[0] = -1;
      pos[1] = -1;
      gh = 3'b000;
    end else begin
      press = gh[1] & ~gh[2];
      gh = {gh[1:0], go};
      for (int u = 0; u < 2; u++) begin
        k = cur_kind(u);
        if (press) begin
          if (k == K_IDLE) begin build(u); pos[u] = 0; end
          else if (k == K_PAUSE) pos[u] = pos[u] + 1;
          else pos[u] = -1;
        end else if (k != K_IDLE && k != K_DONE && k != K_PAUSE) begin
          pos[u] = pos[u] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [25:0] e, a;
    kind_t k;
    for (int u = 0; u < 2; u++) begin
      k = cur_kind(u);
      if (!rst) begin
        e = exp_vec(k, cur_iter(u), (pos[u] < 0) ? 1'b0 : po[u][pos[u]]);
        a = act_vec(u);
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL cycle_check dut%0d t=%0t step=%s actual=%h expected=%h", u, $time, k.name(), a, e);
        end
      end
      bo[u] = !rst && (k == K_TEST) && (cur_iter(u) + 1 == bo_at);
    end
  end

  // ---------------- directed stimulus with literal pins ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic press_go();
    go = 1'b1;
    tick(2);
    go = 1'b0;
  endtask

  task automatic wait_over(input int u, input int budget, input string name, output int cyc);
    cyc = 0;
    while (!over[u] && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!over[u]) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual_over=0 expected_over=1", name);
    end
  endtask

`ifdef FIB_SEQ_CTRL_SSTEP_EN
  task automatic wait_pause(input int budget, input string name);
    int cyc;
    cyc = 0;
    while (!(busy[0] && f_o[0] == 3'd0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!(busy[0] && f_o[0] == 3'd0)) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual_busy=%0d expected_pause", name, busy[0]);
    end
  endtask
`endif

  initial begin
    int c, c2;
    rst = 1'b1; go = 1'b0; bo_at = 0;
    tick(3);
    lit("reset_outputs_dut0", act_vec(0), 0);
    lit("reset_outputs_dut1", act_vec(1), 0);
    rst = 1'b0;
    tick(3);

    // single press held 10 cycles, bo on the 5th TEST
    bo_at = 5;
    go = 1'b1;
    tick(1); lit("edge1_tsw", tsw[0], 0);
    tick(1); lit("edge2_tsw", tsw[0], 0);
    tick(1);
    lit("edge3_tsw", tsw[0], 1);
    lit("edge3_ldn", ldn[0], 1);
    lit("edge3_f", f_o[0], 2);
    tick(7);
    go = 1'b0;
    wait_over(0, 100, "four_iter_done", c);
    lit("four_iter_latency", c + 7, 26);
    lit("four_iter_iter", iter_o[0], 4);
    lit("four_iter_ovf", ovf[0], 0);
    lit("four_iter_busy", busy[0], 0);
    lit("cap3_on_four_iter_iter", iter_o[1], 3);
    lit("cap3_on_four_iter_ovf", ovf[1], 1);

    // press in DONE returns to IDLE
    press_go(); tick(3);
    lit("done_to_idle_over", over[0], 0);
    lit("done_to_idle_iter", iter_o[0], 0);

    // immediate termination
    bo_at = 1;
    press_go(); tick(1);
    wait_over(0, 50, "immediate_done", c);
    lit("immediate_latency", c, 6);
    lit("immediate_iter", iter_o[0], 0);
    lit("immediate_over", over[0], 1);
    lit("immediate_ovf", ovf[0], 0);
    press_go(); tick(3);

    // iteration cap with bo held low
    bo_at = 0;
    press_go(); tick(1);
    wait_over(1, 100, "cap3_done", c);
    lit("cap3_latency", c, 21);
    lit("cap3_iter", iter_o[1], 3);
    lit("cap3_ovf", ovf[1], 1);
    lit("cap3_over", over[1], 1);
    wait_over(0, 1400, "cap255_done", c2);
    lit("cap255_latency", c + c2, 1281);
    lit("cap255_iter", iter_o[0], 255);
    lit("cap255_ovf", ovf[0], 1);
    press_go(); tick(1);
    lit("idle_after_cap_dut1", act_vec(1), 0);
    lit("idle_after_cap_dut0", act_vec(0), 0);
    tick(2);

    // abort during WB of iteration 2
    press_go(); tick(1);
    tick(10);
    go = 1'b1;
    tick(2);
    lit("abort_pre_tout", tout[0], 1);
    lit("abort_pre_ldp", ldp[0], 1);
    lit("abort_pre_iter", iter_o[0], 1);
    go = 1'b0;
    tick(1);
    lit("abort_busy", busy[0], 0);
    lit("abort_iter", iter_o[0], 0);
    lit("abort_over", over[0], 0);
    tick(3);

    // asynchronous reset in ADD
    press_go(); tick(1);
    tick(5);
    lit("mid_add_tp", tp[0], 1);
    rst = 1'b1;
    #1;
    lit("async_reset_dut0", act_vec(0), 0);
    lit("async_reset_dut1", act_vec(1), 0);
    tick(1);
    rst = 1'b0;
    tick(3);

    // go held high across reset release
    bo_at = 1;
    rst = 1'b1; go = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    lit("press_across_reset_tsw", tsw[0], 1);
    tick(1);
    go = 1'b0;
    wait_over(0, 50, "press_across_reset_done", c);
    press_go(); tick(3);

`ifdef FIB_SEQ_CTRL_SSTEP_EN
    sstep = 1'b1;
    bo_at = 3;
    press_go(); tick(1);
    wait_pause(50, "sstep_pause1");
    lit("sstep_pause1_iter", iter_o[0], 1);
    lit("sstep_pause1_enables", act_vec(0) & 26'h3FFFF00, 26'h0000100);
    tick(3);
    lit("sstep_pause1_held", busy[0], 1);
    press_go(); tick(1);
    lit("sstep_resume_f", f_o[0], 4);
    wait_pause(50, "sstep_pause2");
    lit("sstep_pause2_iter", iter_o[0], 2);
    press_go(); tick(1);
    wait_over(0, 50, "sstep_done", c);
    lit("sstep_done_iter", iter_o[0], 2);
    lit("sstep_done_ovf", ovf[0], 0);
    press_go(); tick(3);
    sstep = 1'b0;
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
